// File: rtl/ustc_line_gen_if.sv
// Line-generator bus: B tile writes and nonzero entries in, accumulator line bundles out.
interface ustc_line_gen_if #(
  parameter int TILE_N  = 4,
  parameter int DW_DATA = 32,
  parameter int DW_POS  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_K    = 3,
  parameter int NUM_IN  = 32,
  parameter int DW_LINE = TILE_N*DW_DATA + DW_POS + DW_CTRL
);
  logic                        b_wr_en;
  logic [DW_K-1:0]             b_wr_k;
  logic [TILE_N*DW_DATA-1:0]   b_wr_data;
  logic                        busy;
  logic                        nz_valid;
  logic                        nz_ready;
  logic [DW_DATA-1:0]          nz_val;
  logic [DW_POS-1:0]           nz_row;
  logic [DW_K-1:0]             nz_k;
  logic [DW_POS-1:0]           nz_col;
  logic                        nz_last;
  logic [DW_POS-1:0]           col;
  logic [NUM_IN*DW_LINE-1:0]   line;
  logic                        input_en;

  modport master (
    output b_wr_en, b_wr_k, b_wr_data, nz_valid, nz_val, nz_row, nz_k, nz_col, nz_last,
    input  busy, nz_ready, col, line, input_en
  );
  modport slave (
    input  b_wr_en, b_wr_k, b_wr_data, nz_valid, nz_val, nz_row, nz_k, nz_col, nz_last,
    output busy, nz_ready, col, line, input_en
  );
endinterface

// File: rtl/ustc_line_gen.sv
// Sparse-core line producer: scales B tile rows by A nonzeros and packs the products into lane bundles.
module ustc_line_gen #(
  parameter int TILE_M  = 4,
  parameter int TILE_K  = 8,
  parameter int TILE_N  = 4,
  parameter int NUM_IN  = TILE_M*TILE_K,
  parameter int DW_DATA = 32,
  parameter int DW_POS  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_K    = $clog2(TILE_K),
  parameter int DW_LINE = TILE_N*DW_DATA + DW_POS + DW_CTRL
) (
  input  logic            clk,
  input  logic            rst,
  ustc_line_gen_if.slave  bus
);
  localparam int DW_CNT = $clog2(NUM_IN+1);
  localparam int DW_LI  = $clog2(NUM_IN);
  localparam logic [DW_CNT-1:0] LAST_SLOT = DW_CNT'(NUM_IN-1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_e;

  state_e                            state_q;
  logic [DW_CNT-1:0]                 cnt_q;
  logic [NUM_IN-1:0][DW_LINE-1:0]    lane_q;
  logic [DW_POS-1:0]                 col_q;
  logic                              last_q;
  logic [TILE_N*DW_DATA-1:0]         b_q [TILE_K];
  logic [TILE_N*DW_DATA-1:0]         prod_d;
  logic [DW_CTRL-1:0]                ctrl_d;

  // Truncated product: low word is identical for signed and unsigned operands.
  always_comb begin
    prod_d = '0;
    for (int j = 0; j < TILE_N; j++)
      prod_d[j*DW_DATA +: DW_DATA] = bus.nz_val * b_q[bus.nz_k][j*DW_DATA +: DW_DATA];
    ctrl_d = '0;
    ctrl_d[DW_CTRL-2] = 1'b1;
    ctrl_d[DW_CTRL-1] = bus.nz_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      b_q     <= '{default: '0};
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (state_q == IDLE && bus.b_wr_en) begin
            b_q[bus.b_wr_k] <= bus.b_wr_data;
          end else if (bus.nz_valid) begin
            lane_q[cnt_q[DW_LI-1:0]] <= {ctrl_d, bus.nz_row, prod_d};
            cnt_q  <= cnt_q + 1'b1;
            last_q <= bus.nz_last;
            if (state_q == IDLE) col_q <= bus.nz_col;
            state_q <= (bus.nz_last || cnt_q == LAST_SLOT) ? EMIT : FILL;
          end
        end
        EMIT: begin
          lane_q  <= '0;
          cnt_q   <= '0;
          state_q <= last_q ? IDLE : FILL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A B write in IDLE stalls the entry for that cycle.
  assign bus.nz_ready = !rst && ((state_q == IDLE && !bus.b_wr_en) || state_q == FILL);
  assign bus.busy     = (state_q != IDLE);
  assign bus.input_en = (state_q == EMIT);
  assign bus.col      = col_q;
  assign bus.line     = lane_q;
endmodule
